// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up initialisation: NOP wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE, then config_done; a software reinit reruns from PRECHARGE.
// Ports: clk, reset_n (sync, active low), reinit (1-cycle pulse, used in DONE);
//        cke, cs_n/ras_n/cas_n/we_n, a[12:0], ba[1:0], config_done (all registered).
module sdram_init_sequencer #(
    parameter int          T_POWERUP   = 5000,
    parameter int          T_RP        = 2,
    parameter int          T_RFC       = 7,
    parameter int          T_MRD       = 2,
    parameter int          NUM_REFRESH = 2,
    parameter logic [12:0] MODE_VALUE  = 13'h020
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reinit,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [12:0] a,
    output logic [1:0]  ba,
    output logic        config_done
);

    localparam int MAX_A = (T_POWERUP > T_RP) ? T_POWERUP : T_RP;
    localparam int MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int MAXT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXT) + 1;
    localparam int RW    = $clog2(NUM_REFRESH + 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    typedef enum logic [3:0] {
        S_RESET,
        S_POWERUP,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC,
        S_LMR,
        S_WAIT_MRD,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  ref_q, ref_d;
    logic           cke_q, cke_d;
    logic [3:0]     cmd_q, cmd_d;
    logic [12:0]    a_q, a_d;
    logic [1:0]     ba_q, ba_d;
    logic           done_q, done_d;
    logic           cnt_zero;
    logic           refs_done;
    logic [RW-1:0]  ref_inc;

    assign cnt_zero = (cnt_q == '0);
    assign ref_inc  = ref_q + RW'(1);
    // In REFRESH the current command is not yet reflected in ref_q.
    assign refs_done = (state_q == S_REF) ? (ref_inc == RW'(NUM_REFRESH))
                                          : (ref_q == RW'(NUM_REFRESH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        unique case (state_q)
            S_RESET: begin
                state_d = S_POWERUP;
                cnt_d   = CW'(T_POWERUP - 1);
            end
            S_POWERUP: begin
                if (cnt_zero) state_d = S_PRE;
                else          cnt_d   = cnt_q - CW'(1);
            end
            S_PRE: begin
                ref_d = '0;
                if (T_RP > 1) begin
                    state_d = S_WAIT_RP;
                    cnt_d   = CW'(T_RP - 2);
                end else begin
                    state_d = S_REF;
                end
            end
            S_WAIT_RP: begin
                if (cnt_zero) state_d = S_REF;
                else          cnt_d   = cnt_q - CW'(1);
            end
            S_REF: begin
                ref_d = ref_inc;
                if (T_RFC > 1) begin
                    state_d = S_WAIT_RFC;
                    cnt_d   = CW'(T_RFC - 2);
                end else begin
                    state_d = refs_done ? S_LMR : S_REF;
                end
            end
            S_WAIT_RFC: begin
                if (cnt_zero) state_d = refs_done ? S_LMR : S_REF;
                else          cnt_d   = cnt_q - CW'(1);
            end
            S_LMR: begin
                if (T_MRD > 1) begin
                    state_d = S_WAIT_MRD;
                    cnt_d   = CW'(T_MRD - 2);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_MRD: begin
                if (cnt_zero) state_d = S_DONE;
                else          cnt_d   = cnt_q - CW'(1);
            end
            S_DONE: begin
                if (reinit) state_d = S_PRE;
            end
            default: state_d = S_RESET;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        a_d    = '0;
        ba_d   = '0;
        done_d = 1'b0;
        unique case (state_d)
            S_PRE: begin
                cmd_d = CMD_PRE;
                a_d   = 13'h400;
            end
            S_REF:   cmd_d  = CMD_REF;
            S_LMR: begin
                cmd_d = CMD_LMR;
                a_d   = MODE_VALUE;
            end
            S_DONE:  done_d = 1'b1;
            default: cmd_d  = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            a_q     <= '0;
            ba_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            ba_q    <= ba_d;
            done_q  <= done_d;
        end
    end

    assign cke                      = cke_q;
    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign a                        = a_q;
    assign ba                       = ba_q;
    assign config_done              = done_q;

endmodule

// File: doc/sdram_init_sequencer.md
Name: sdram_init_sequencer

Overview:
- Drives the SDRAM power-up initialisation sequence: power-up NOP wait, PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER.
- Then asserts config_done, which feeds the SDRAM controller's command mux and the software-visible SDRAM config status register.
- Owns the SDRAM command pins until config_done is high; the main controller owns them afterwards.
- Supports a software-triggered re-initialisation that skips the power-up wait.

Parameters:
- T_POWERUP, 5000: NOP cycles with CKE high before first PRECHARGE (≥1).
- T_RP, 2: cycles from PRECHARGE to next command (≥1).
- T_RFC, 7: cycles from AUTO REFRESH to next command (≥1).
- T_MRD, 2: cycles from LOAD MODE to config_done (≥1).
- NUM_REFRESH, 2: AUTO REFRESH commands issued (≥1).
- MODE_VALUE, 13'h020: mode register value on a (CAS 2, burst length 1, sequential).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- reinit  in  1  single-cycle request to rerun the sequence from PRECHARGE
- cke  out  1  SDRAM clock enable
- cs_n  out  1  command chip select
- ras_n  out  1  command RAS
- cas_n  out  1  command CAS
- we_n  out  1  command WE
- a  out  13  SDRAM address
- ba  out  2  bank address
- config_done  out  1  initialisation complete, level

Behaviour:
- All outputs registered.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP 0111
  - PRECHARGE 0010
  - AUTO REFRESH 0001
  - LOAD MODE 0000
- Reset (reset_n low at a clk edge), applied on the same edge from any state:
  - cke=0, command NOP, a=0, ba=0, config_done=0
  - state RESET, counters cleared
- Cycle numbering: cycle 0 is the first cycle whose outputs reflect reset_n high.
- States and transitions:
  - POWERUP: cycles 0..T_POWERUP-1; cke=1, NOP.
  - PRECHARGE: one cycle at T_POWERUP; a[10]=1 (all banks), other a bits 0, ba=0.
  - WAIT_RP: NOP for T_RP-1 cycles; skipped when T_RP=1.
  - REFRESH: one cycle, AUTO REFRESH.
  - WAIT_RFC: NOP for T_RFC-1 cycles. Then back to REFRESH until NUM_REFRESH refreshes are issued, else LOAD_MODE.
  - LOAD_MODE: one cycle; a=MODE_VALUE, ba=0.
  - WAIT_MRD: NOP for T_MRD-1 cycles.
  - DONE: config_done=1, NOP, cke=1; held indefinitely.
- Command spacing is exact:
  - PRECHARGE→REFRESH = T_RP cycles
  - REFRESH→REFRESH and REFRESH→LOAD_MODE = T_RFC cycles
  - LOAD_MODE→config_done = T_MRD cycles
- Total latency to config_done = T_POWERUP + T_RP + NUM_REFRESH·T_RFC + T_MRD cycles.
- a and ba are 0 in every NOP cycle.
- Down-counters are sized by $clog2 of the largest timing parameter plus 1. The refresh counter is sized by $clog2(NUM_REFRESH+1). No wrap is possible.
- reinit:
  - Sampled only in DONE. On the next cycle config_done=0 and PRECHARGE is issued; the sequence then runs as above.
  - cke stays 1 throughout.
  - Ignored in all other states; it is not queued.
- reset_n low mid-sequence or in DONE: immediate return to RESET outputs on that edge. The sequence restarts from POWERUP after release.
- reset_n and reinit together: reset wins.
- config_done never glitches high before LOAD_MODE + T_MRD.

Test Plan:
- Timing with T_POWERUP=10, T_RP=2, T_RFC=7, T_MRD=2, NUM_REFRESH=2; release reset:
  - cke=1 from cycle 0, NOP cycles 0–9
  - PRECHARGE with a=13'h400 at cycle 10
  - REFRESH at 12 and 19
  - LOAD_MODE with a=13'h020 at 26
  - config_done=1 from 28, held
- Minimum timings (all T_* = 1, NUM_REFRESH=1):
  - PRECHARGE at 1, REFRESH at 2, LOAD_MODE at 3, config_done at 4
  - no NOP gaps between commands
- reinit pulse at cycle 40 (in DONE) with the first scenario's parameters:
  - config_done=0 at 41, PRECHARGE at 41
  - REFRESH at 43 and 50, LOAD_MODE at 57, config_done at 59
  - cke never drops
- reinit pulse at cycle 15 (mid-sequence): ignored; sequence identical to the first scenario, config_done at 28.
- reset_n low at cycle 20 for 3 cycles: outputs go to cke=0, NOP, config_done=0 on that edge; after release PRECHARGE occurs 10 cycles later.
- Check every cycle: a=0 and ba=0 whenever the command is NOP.
